regfile_param: RTL and testbench

- Parametrised architectural register file for the pipelined AArch64 core. It generalises the single write-enabled 64-bit register into a DEPTH x WIDTH array.
- One synchronous write port and READ_PORTS combinational read ports.
- Hardwired zero register (XZR).
- Optional same-cycle write-to-read bypass, so the decode stage sees a value written back in that same cycle.

---
 rtl/regfile_param.sv | 93 +++++++++
 tb/tb_regfile_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//
// Parametrised architectural register file for the pipelined AArch64 core.
// It holds DEPTH registers of WIDTH bits each. There is one synchronous write
// port and READ_PORTS combinational read ports. One index (ZERO_REG, XZR by
// default) is hardwired to zero. An optional same-cycle write-to-read bypass
// lets decode see a value that is being written back in that cycle.
//
// Handshake: there is none. A write is a single-cycle command that is
// qualified by RegWrite and captured on the rising edge of clk. Reads are
// pure combinational lookups with no valid or ready qualification.
//
// Parameters:
//   WIDTH      bits per register
//   DEPTH      number of registers (power of two, >= 2)
//   ADDR_W     derived index width, $clog2(DEPTH)
//   READ_PORTS number of independent read ports (1..4)
//   ZERO_REG   index that always reads 0 and ignores writes
//   BYPASS     1 = a read of the register being written returns WriteData
//              0 = it returns the stored (old) value
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high; clears every register
//   RegWrite      in   write enable
//   WriteRegister in   [ADDR_W]             destination index
//   WriteData     in   [WIDTH]              write data
//   ReadRegister  in   [READ_PORTS*ADDR_W]  port p index at [p*ADDR_W +: ADDR_W]
//   ReadData      out  [READ_PORTS*WIDTH]   port p data at [p*WIDTH +: WIDTH]
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 32,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = DEPTH - 1,
    parameter int BYPASS     = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RegWrite,
    input  logic [ADDR_W-1:0]            WriteRegister,
    input  logic [WIDTH-1:0]             WriteData,
    input  logic [READ_PORTS*ADDR_W-1:0] ReadRegister,
    output logic [READ_PORTS*WIDTH-1:0]  ReadData
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [WIDTH-1:0] regs [DEPTH];

    // A write is real only when it is enabled and does not target the zero
    // register. The same qualifier gates the bypass, so XZR can never leak
    // WriteData onto a read port.
    logic write_hit;
    assign write_hit = RegWrite && (WriteRegister != ZERO_IDX);

    // Storage. Each cell either holds or loads (an enable mux, not a gated
    // clock). The ZERO_REG cell is cleared by reset and is never loaded, so
    // it stays 0. The read path also forces it to 0, so its stored value is
    // irrelevant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    // Read ports. Each port has three cases, in priority order:
    //   1. zero register         -> 0
    //   2. same-cycle write hit  -> WriteData (only when BYPASS=1)
    //   3. otherwise             -> the stored value
    // While reset is high the stored values are already 0, so the result of
    // a read under reset falls out of the same priority list.
    always_comb begin
        ReadData = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (ReadRegister[p*ADDR_W +: ADDR_W] == ZERO_IDX) begin
                ReadData[p*WIDTH +: WIDTH] = '0;
            end else if ((BYPASS != 0) && write_hit &&
                         (WriteRegister == ReadRegister[p*ADDR_W +: ADDR_W])) begin
                ReadData[p*WIDTH +: WIDTH] = WriteData;
            end else begin
                ReadData[p*WIDTH +: WIDTH] = regs[ReadRegister[p*ADDR_W +: ADDR_W]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//
// Bench for regfile_param. It drives two default-geometry instances from the
// same stimulus: one with BYPASS=1 and one with BYPASS=0. It also drives a
// separate 32-bit, 16-entry, 3-port instance. Inputs change on the falling
// edge of clk. Outputs are sampled 1 ns later, which is well before the next
// rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- default-geometry DUTs ----------------
    logic         we;
    logic [4:0]   wa;
    logic [63:0]  wd;
    logic [9:0]   ra;
    logic [127:0] rd_byp;
    logic [127:0] rd_nob;

    regfile_param #(.BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa),
        .WriteData(wd), .ReadRegister(ra), .ReadData(rd_byp)
    );

    regfile_param #(.BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa),
        .WriteData(wd), .ReadRegister(ra), .ReadData(rd_nob)
    );

    // ---------------- small-geometry DUT ----------------
    logic        p_we;
    logic [3:0]  p_wa;
    logic [31:0] p_wd;
    logic [11:0] p_ra;
    logic [95:0] p_rd;

    regfile_param #(.WIDTH(32), .DEPTH(16), .READ_PORTS(3), .ZERO_REG(15)) u_par (
        .clk(clk), .reset(reset), .RegWrite(p_we), .WriteRegister(p_wa),
        .WriteData(p_wd), .ReadRegister(p_ra), .ReadData(p_rd)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        we = 1'b1; wa = a; wd = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic set_read(input logic [4:0] r0, input logic [4:0] r1);
        ra = {r1, r0};
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] e0_byp;
        logic [63:0] e1_byp;
        logic [63:0] e0_nob;
        logic [63:0] e1_nob;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        // Each vector is applied before a rising edge and checked pre-edge.
        // The state at the start is all-zero, straight after reset.
        vecs[0]  = '{1'b1, 5'd5,  DB,      5'd5,  5'd6,  DB,      64'h0,   64'h0,   64'h0};
        vecs[1]  = '{1'b1, 5'd30, FF,      5'd5,  5'd30, DB,      FF,      DB,      64'h0};
        vecs[2]  = '{1'b0, 5'd3,  64'h55,  5'd5,  5'd30, DB,      FF,      DB,      FF};
        vecs[3]  = '{1'b0, 5'd3,  64'h55,  5'd3,  5'd6,  64'h0,   64'h0,   64'h0,   64'h0};
        vecs[4]  = '{1'b1, 5'd31, 64'h1234,5'd31, 5'd31, 64'h0,   64'h0,   64'h0,   64'h0};
        vecs[5]  = '{1'b0, 5'd0,  64'h0,   5'd31, 5'd31, 64'h0,   64'h0,   64'h0,   64'h0};
        vecs[6]  = '{1'b0, 5'd0,  64'h0,   5'd30, 5'd5,  FF,      DB,      FF,      DB};
        vecs[7]  = '{1'b1, 5'd7,  64'hAA,  5'd7,  5'd7,  64'hAA,  64'hAA,  64'h0,   64'h0};
        vecs[8]  = '{1'b1, 5'd7,  64'hBB,  5'd7,  5'd7,  64'hBB,  64'hBB,  64'hAA,  64'hAA};
        vecs[9]  = '{1'b0, 5'd0,  64'h0,   5'd7,  5'd7,  64'hBB,  64'hBB,  64'hBB,  64'hBB};
        vecs[10] = '{1'b1, 5'd7,  64'hCC,  5'd7,  5'd8,  64'hCC,  64'h0,   64'hBB,  64'h0};
        vecs[11] = '{1'b0, 5'd0,  64'h0,   5'd7,  5'd30, 64'hCC,  FF,      64'hCC,  FF};
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        we = 1'b0; wa = '0; wd = '0; ra = '0;
        p_we = 1'b0; p_wa = '0; p_wd = '0; p_ra = '0;

        // Reset state
        #2 reset = 1'b1;
        set_read(5'd0, 5'd5);
        #1;
        check("reset_byp_p0", rd_byp[63:0],   64'h0);
        check("reset_byp_p1", rd_byp[127:64], 64'h0);
        check("reset_nob_p0", rd_nob[63:0],   64'h0);
        check("reset_nob_p1", rd_nob[127:64], 64'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            set_read(vecs[i].ra0, vecs[i].ra1);
            #1;
            check($sformatf("vec%0d_byp_p0", i), rd_byp[63:0],   vecs[i].e0_byp);
            check($sformatf("vec%0d_byp_p1", i), rd_byp[127:64], vecs[i].e1_byp);
            check($sformatf("vec%0d_nob_p0", i), rd_nob[63:0],   vecs[i].e0_nob);
            check($sformatf("vec%0d_nob_p1", i), rd_nob[127:64], vecs[i].e1_nob);
        end
        @(negedge clk);
        we = 1'b0;

        // Preload X0..X30, then assert reset mid-cycle (away from any edge).
        for (int i = 0; i < 31; i++) begin
            do_write(5'(i), 64'h1000 + 64'(i));
        end
        @(negedge clk);
        set_read(5'd0, 5'd30);
        #1;
        check("preload_x0",  rd_nob[63:0],   64'h1000);
        check("preload_x30", rd_nob[127:64], 64'h101E);
        #1 reset = 1'b1;
        #1;
        check("async_rst_byp_x0",  rd_byp[63:0],   64'h0);
        check("async_rst_byp_x30", rd_byp[127:64], 64'h0);
        check("async_rst_nob_x0",  rd_nob[63:0],   64'h0);
        check("async_rst_nob_x30", rd_nob[127:64], 64'h0);
        // Sweep the rest of the registers while reset is still held.
        for (int i = 1; i < 30; i++) begin
            set_read(5'(i), 5'(30 - i));
            #1;
            check($sformatf("rst_sweep_x%0d", i),      rd_nob[63:0],   64'h0);
            check($sformatf("rst_sweep_x%0d", 30 - i), rd_byp[127:64], 64'h0);
        end

        // Reset beats RegWrite: hold reset across an edge while writing X3.
        // A bypass hit under reset still returns WriteData.
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 64'h55;
        set_read(5'd3, 5'd3);
        #1;
        check("rst_bypass_byp", rd_byp[63:0], 64'h55);
        check("rst_bypass_nob", rd_nob[63:0], 64'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_prio_x3_byp", rd_byp[63:0], 64'h0);
        check("rst_prio_x3_nob", rd_nob[127:64], 64'h0);

        // The first edge after reset is released takes a write.
        do_write(5'd3, 64'h77);
        #1;
        check("post_rst_write_x3", rd_nob[63:0], 64'h77);

        // Small-geometry instance: write R2, read {2,15,2}.
        @(negedge clk);
        p_we = 1'b1; p_wa = 4'd2; p_wd = 32'hCAFE_F00D;
        p_ra = {4'd2, 4'd15, 4'd2};
        #1;
        check("par_bypass_p0", 64'(p_rd[31:0]), 64'hCAFE_F00D);
        check("par_bypass_p1", 64'(p_rd[63:32]), 64'h0);
        @(negedge clk);
        p_we = 1'b1; p_wa = 4'd15; p_wd = 32'h1234_5678;
        #1;
        check("par_p0", 64'(p_rd[31:0]),  64'hCAFE_F00D);
        check("par_p1", 64'(p_rd[63:32]), 64'h0);
        check("par_p2", 64'(p_rd[95:64]), 64'hCAFE_F00D);
        @(negedge clk);
        p_we = 1'b0;
        #1;
        check("par_zero_after", 64'(p_rd[63:32]), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
